// File: rtl/neurram_spi_engine.sv
// neurram_spi_engine: multi-channel SPI scan-chain shift engine with stream load/unload
module neurram_spi_engine #(
  parameter int SPI_LENGTH = 256,
  parameter int N_CH = 2,
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cfg_write,
  input  logic             cfg_read,
  input  logic [3:0]       cfg_frames,
  input  logic [7:0]       cfg_clk_div,
  input  logic [3:0]       cfg_extra,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [3:0]       frame_cnt,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             spi_clk,
  output logic [N_CH-1:0]  shift_out,
  input  logic [N_CH-1:0]  shift_in
);
  localparam int BPW = W / N_CH;
  localparam int WPF = SPI_LENGTH / BPW;
  localparam int LW = $clog2(SPI_LENGTH);
  localparam int CW = $clog2(SPI_LENGTH + 16);
  localparam int IW = WPF > 1 ? $clog2(WPF) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, UNLOAD, DONE} state_t;
  state_t state, nxt, fin;
  logic c_write, c_read;
  logic [3:0] c_frames, c_extra;
  logic [7:0] c_div, div_cnt;
  logic [CW-1:0] bit_cnt, limit;
  logic [IW-1:0] word_idx;
  logic [LW-1:0] base;
  logic ph_end, last, bit_end, w_end, rise, fall, frame_inc;
  assign ph_end = div_cnt == c_div;
  assign last = frame_cnt == c_frames - 4'd1;
  assign limit = CW'(SPI_LENGTH) + (last ? CW'(c_extra) : '0);
  assign bit_end = bit_cnt + CW'(1) == limit;
  assign w_end = word_idx == IW'(WPF - 1);
  assign rise = state == SHIFT_LO && ph_end;
  assign fall = state == SHIFT_HI && ph_end;
  assign fin = last ? DONE : c_write ? LOAD : SHIFT_LO;
  assign in_ready = state == LOAD;
  assign out_valid = state == UNLOAD;
  assign base = LW'(word_idx * BPW);
  assign frame_inc = !abort && ((fall && bit_end && !c_read) || (state == UNLOAD && out_ready && w_end));
  // next-state selection; abort wins over every transition
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = !start ? IDLE : cfg_frames == 4'd0 ? DONE : cfg_write ? LOAD : SHIFT_LO;
      LOAD:     nxt = in_valid && w_end ? SHIFT_LO : LOAD;
      SHIFT_LO: nxt = ph_end ? SHIFT_HI : SHIFT_LO;
      SHIFT_HI: nxt = !ph_end ? SHIFT_HI : !bit_end ? SHIFT_LO : c_read ? UNLOAD : fin;
      UNLOAD:   nxt = out_ready && w_end ? fin : UNLOAD;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  // control state, registered outputs, divider and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      spi_clk <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      c_write <= 1'b0;
      c_read <= 1'b0;
      c_frames <= '0;
      c_extra <= '0;
      c_div <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      word_idx <= '0;
      frame_cnt <= '0;
    end else begin
      state <= nxt;
      spi_clk <= nxt == SHIFT_HI;
      busy <= nxt != IDLE && nxt != DONE;
      done <= nxt == DONE;
      if (state == IDLE && start) begin
        c_write <= cfg_write;
        c_read <= cfg_read;
        c_frames <= cfg_frames;
        c_extra <= cfg_extra;
        c_div <= cfg_clk_div;
      end
      div_cnt <= nxt == state && (state == SHIFT_LO || state == SHIFT_HI) ? div_cnt + 8'd1 : '0;
      bit_cnt <= abort ? '0 : fall ? (bit_end ? '0 : bit_cnt + CW'(1)) : bit_cnt;
      word_idx <= abort ? '0 : (state == LOAD && in_valid) || (state == UNLOAD && out_ready) ? (w_end ? '0 : word_idx + IW'(1)) : word_idx;
      frame_cnt <= state == IDLE && start ? '0 : frame_inc ? frame_cnt + 4'd1 : frame_cnt;
    end
  end
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [SPI_LENGTH-1:0] tx, rx;
    logic [BPW-1:0] tx_w, rx_w;
    for (genvar j = 0; j < BPW; j++) begin : g_bit
      assign tx_w[j] = in_data[j*N_CH+c];
      assign out_data[j*N_CH+c] = rx_w[j];
    end
    assign rx_w = rx[base +: BPW];
    assign shift_out[c] = tx[0];
    // per-channel tx load/shift on falling spi_clk, rx capture on rising spi_clk
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tx <= '0;
        rx <= '0;
      end else begin
        if (state == LOAD && in_valid) tx[base +: BPW] <= tx_w;
        else if (fall) tx <= tx >> 1;
        if (rise) rx <= {shift_in[c], rx[SPI_LENGTH-1:1]};
      end
    end
  end
endmodule

// File: tb/tb_neurram_spi_engine.sv
// tb_neurram_spi_engine: directed self-checking bench for neurram_spi_engine
module tb_neurram_spi_engine;
  logic clk = 0, rst, start, cfg_write, cfg_read, abort;
  logic [3:0] cfg_frames, cfg_extra, frame_cnt;
  logic [7:0] cfg_clk_div;
  logic busy, done, in_valid, in_ready, out_valid, out_ready, spi_clk;
  logic [31:0] in_data, out_data;
  logic [1:0] shift_out, shift_in, si_c;
  logic lb;
  int total = 0, bad = 0, pulses = 0, dones = 0, run_len = 0, last_hi = 0, last_lo = 0;
  logic sp_q = 0;
  logic [5:0] so_h = 0;

  neurram_spi_engine dut (
    .clk(clk), .rst(rst), .start(start), .cfg_write(cfg_write), .cfg_read(cfg_read),
    .cfg_frames(cfg_frames), .cfg_clk_div(cfg_clk_div), .cfg_extra(cfg_extra), .abort(abort),
    .busy(busy), .done(done), .frame_cnt(frame_cnt), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .spi_clk(spi_clk), .shift_out(shift_out), .shift_in(shift_in)
  );

  assign shift_in = lb ? shift_out : si_c;
  always #5 clk = ~clk;

  // spi_clk pulse count, phase lengths, tx bit seen at each rising edge, done pulses
  always @(negedge clk) begin
    sp_q <= spi_clk;
    run_len <= spi_clk == sp_q ? run_len + 1 : 1;
    if (spi_clk != sp_q) begin
      if (sp_q) last_hi <= run_len;
      else last_lo <= run_len;
    end
    if (spi_clk && !sp_q) begin
      pulses <= pulses + 1;
      so_h <= {so_h[3:0], shift_out};
    end
    if (done) dones <= dones + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic produce(input int n, input logic [31:0] b0, input logic [31:0] st, input int ga, output int k);
    int gl = 0, to = 0;
    k = 0;
    while (k < n && to < 20000) begin
      if (gl > 0) begin
        in_valid = 0;
        gl--;
        check("gap_ready", in_ready, 1);
        check("gap_spiclk", spi_clk, 0);
      end else begin
        in_valid = 1;
        in_data = b0 + 32'(k) * st;
        if (in_ready) begin
          k++;
          if (k - 1 == ga) gl = 5;
        end
      end
      @(negedge clk);
      to++;
    end
    in_valid = 0;
  endtask

  task automatic consume(input int n, input logic [31:0] b0, input logic [31:0] st, input bit tog,
                         input bit uc, input logic [31:0] ec, output int cnt);
    int to = 0;
    bit ph = 0, hv = 0;
    logic [31:0] hd = 0;
    cnt = 0;
    while (cnt < n && to < 20000) begin
      ph = ~ph;
      out_ready = tog ? ph : 1'b1;
      if (out_valid) begin
        if (hv) check("hold", out_data, hd);
        if (out_ready) begin
          check("word", out_data, uc ? ec : b0 + 32'(cnt) * st);
          cnt++;
          hv = 0;
        end else begin
          hd = out_data;
          hv = 1;
        end
      end
      @(negedge clk);
      to++;
    end
    out_ready = 0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!done && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, done, 1);
  endtask

  task automatic run(input bit w, input bit r, input logic [3:0] fr, input logic [3:0] ex, input logic [7:0] dv,
                     input logic [31:0] b0, input logic [31:0] st, input int ga, input bit tog, input bit uc,
                     input logic [31:0] ec, input int exp_p, input string tag);
    int p0, d0, np, nc;
    @(posedge clk);
    p0 = pulses;
    d0 = dones;
    @(negedge clk);
    cfg_write = w;
    cfg_read = r;
    cfg_frames = fr;
    cfg_extra = ex;
    cfg_clk_div = dv;
    start = 1;
    @(negedge clk);
    start = 0;
    fork
      produce(w ? 16 * int'(fr) : 0, b0, st, ga, np);
      consume(r ? 16 * int'(fr) : 0, b0, st, tog, uc, ec, nc);
    join
    wait_done(tag);
    @(posedge clk);
    check({tag, "_nin"}, np, w ? 16 * int'(fr) : 0);
    check({tag, "_nout"}, nc, r ? 16 * int'(fr) : 0);
    check({tag, "_pulses"}, pulses - p0, exp_p);
    check({tag, "_dones"}, dones - d0, 1);
    check({tag, "_frames"}, frame_cnt, fr);
  endtask

  initial begin
    int p0, d0, np, to, t;
    rst = 1; start = 0; abort = 0; cfg_write = 0; cfg_read = 0; cfg_frames = 0; cfg_extra = 0;
    cfg_clk_div = 0; in_data = 0; in_valid = 0; out_ready = 0; lb = 0; si_c = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_spiclk", spi_clk, 0);
    check("rst_inready", in_ready, 0);
    check("rst_outvalid", out_valid, 0);
    check("rst_framecnt", frame_cnt, 0);
    check("rst_shiftout", shift_out, 0);
    check("rst_outdata", out_data, 0);

    lb = 1;
    run(1, 1, 4'd1, 4'd0, 8'd0, 32'h0, 32'h1, -1, 0, 0, 32'h0, 256, "t1");
    check("t1_hi", last_hi, 1);
    check("t1_lo", last_lo, 1);

    lb = 0;
    si_c = 2'b01;
    run(0, 1, 4'd1, 4'd0, 8'd3, 32'h0, 32'h0, -1, 1, 1, 32'h5555_5555, 256, "t2");
    check("t2_hi", last_hi, 4);
    check("t2_lo", last_lo, 4);

    lb = 1;
    run(1, 1, 4'd1, 4'd0, 8'd0, 32'h1234_5678, 32'h0F0F_1111, 7, 0, 0, 32'h0, 256, "t3");

    run(1, 0, 4'd3, 4'd2, 8'd0, 32'hFFFF_FFFF, 32'h0, -1, 0, 0, 32'h0, 770, "t4");
    check("t4_flush", so_h[3:0], 0);
    check("t4_lastdata", so_h[5:4], 2'b11);

    @(posedge clk);
    p0 = pulses;
    d0 = dones;
    @(negedge clk);
    cfg_write = 1; cfg_read = 1; cfg_frames = 1; cfg_extra = 0; cfg_clk_div = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    produce(16, 32'hCAFE_0000, 32'h0001_0003, -1, np);
    check("t5_nin", np, 16);
    to = 0;
    while (pulses < p0 + 100 && to < 5000) begin
      @(posedge clk);
      to++;
    end
    check("t5_reach", to < 5000, 1);
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("t5_busy", busy, 0);
    check("t5_spiclk", spi_clk, 0);
    check("t5_inready", in_ready, 0);
    check("t5_outvalid", out_valid, 0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    check("t5_nodone", dones - d0, 0);
    check("t5_idle", busy, 0);
    run(1, 1, 4'd1, 4'd0, 8'd0, 32'h8000_0001, 32'h1357_9BDF, -1, 0, 0, 32'h0, 256, "t5b");

    @(posedge clk);
    p0 = pulses;
    d0 = dones;
    @(negedge clk);
    cfg_write = 0; cfg_read = 0; cfg_frames = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    check("t6_noop_done", done, 1);
    check("t6_noop_busy", busy, 0);
    @(negedge clk);
    check("t6_noop_pulse", done, 0);
    @(posedge clk);
    check("t6_noop_spi", pulses - p0, 0);
    check("t6_noop_dones", dones - d0, 1);
    @(posedge clk);
    p0 = pulses;
    d0 = dones;
    @(negedge clk);
    cfg_frames = 1;
    cfg_clk_div = 0;
    cfg_extra = 0;
    start = 1;
    t = 0;
    while (t < 2000) begin
      @(negedge clk);
      t++;
      cfg_frames = 0;
      if (done) break;
      start = t == 50;
    end
    start = 0;
    check("t6_latency", t, 513);
    @(posedge clk);
    check("t6_pulses", pulses - p0, 256);
    check("t6_frames", frame_cnt, 1);
    check("t6_dones", dones - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/neurram_spi_engine.md
Name: neurram_spi_engine

Overview:
- Parametrised SPI shift engine for NeurRAM core scan chains; next generation of the two-channel, fixed 256-bit SPI controller.
- Single clock domain. Host-side FIFOs are external, and the engine talks to them over valid/ready streams.
- Adds:
  - N_CH channels of SPI_LENGTH bits each.
  - Programmable spi_clk divider.
  - Multi-frame write/read with per-frame load/unload.
  - Trailing flush bits.
  - Abort.
  - Stall-safe backpressure.

Parameters:
- SPI_LENGTH, 256, bits per channel per frame; must be a multiple of BPW.
- N_CH, 2, number of parallel SPI data channels; must divide W.
- W, 32, stream word width.
- Derived: BPW = W/N_CH bits per channel per word; WPF = SPI_LENGTH/BPW words per frame (default 16).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; sampled only when busy=0
- cfg_write  in  1  load tx words from in stream each frame
- cfg_read  in  1  unload rx words to out stream each frame
- cfg_frames  in  4  frames per operation; 0 means no-op
- cfg_clk_div  in  8  spi_clk half-period = cfg_clk_div+1 clk cycles
- cfg_extra  in  4  extra spi_clk pulses after the last frame's shift
- abort  in  1  synchronous abort to IDLE
- busy  out  1  high from the cycle after accepted start until return to IDLE
- done  out  1  one-cycle pulse on normal completion
- frame_cnt  out  4  frames completed in current operation
- in_data  in  W  tx word
- in_valid  in  1  tx word valid
- in_ready  out  1  engine accepts tx word
- out_data  out  W  rx word
- out_valid  out  1  rx word valid
- out_ready  in  1  consumer accepts rx word
- spi_clk  out  1  registered SPI clock
- shift_out  out  N_CH  serial tx data; LSB of each channel's tx register
- shift_in  in  N_CH  serial rx data

Behaviour:
Reset:
- All outputs 0 and state IDLE.
- tx and rx registers, counters and divider all 0.

Word packing, shared by load and unload:
- Word bit b maps to channel b%N_CH, channel bit index word_idx*BPW + b/N_CH.

States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, UNLOAD, DONE.

IDLE:
- Latch cfg_* on start.
- cfg_frames=0 → DONE.
- Otherwise go to LOAD if cfg_write, else SHIFT_LO.
- start while busy is ignored.

LOAD:
- in_ready=1 combinationally, in this state only.
- Each in_valid&&in_ready writes the word at word_idx and increments word_idx.
- Gaps in in_valid simply hold the state.
- After word WPF-1 is accepted: word_idx=0, next SHIFT_LO.

SHIFT_LO / SHIFT_HI:
- spi_clk is 0 in LO and 1 in HI. Each phase lasts cfg_clk_div+1 cycles, counted by the divider.
- On the edge ending LO (spi_clk rising): every rx channel register shifts right with shift_in[ch] into its MSB.
- On the edge ending HI (spi_clk falling): every tx register shifts right, zero-filled, and bit_cnt increments.
- Frame end is bit_cnt==SPI_LENGTH, or SPI_LENGTH+cfg_extra when the frame is the last one. At frame end:
  - bit_cnt clears.
  - Next state is UNLOAD if cfg_read.
  - Otherwise frame_cnt increments, then next state is DONE if it was the last frame, else LOAD (if cfg_write) or SHIFT_LO.

UNLOAD:
- out_valid=1, and out_data is the packed word for word_idx.
- out_data must stay stable while out_ready=0.
- On out_valid&&out_ready: word_idx increments.
- After word WPF-1 is taken: frame_cnt increments and the next state follows the same rule as frame end without cfg_read.
- On the last frame, extra bits have already been shifted into rx before unload, so the unloaded data is offset by cfg_extra.

DONE:
- done=1 and busy=0 for one cycle, then IDLE.
- frame_cnt holds its value until the next start.

Abort:
- Overrides everything. Next cycle: IDLE, spi_clk=0, in_ready=0, out_valid=0, no done pulse.
- tx/rx contents are undefined afterwards.

Reset mid-operation:
- Asynchronous return to the reset values listed above.

Widths:
- bit_cnt is wide enough for SPI_LENGTH+15.
- word_idx uses clog2(WPF) bits, with a minimum of 1.

Latency:
- The first spi_clk rising edge occurs cfg_clk_div+1 cycles after entering SHIFT_LO.

Test Plan:
1. **Loopback, write+read, one frame.** Default params, shift_in=shift_out, cfg_write=cfg_read=1, frames=1, clk_div=0, extra=0. Stream 16 words 0x0000_0000+k.
   - Required: exactly 256 spi_clk pulses with a 2-cycle period.
   - Required: 16 out words equal to the input words; done pulses once.
2. **Divider and backpressure.** clk_div=3, read-only, shift_in[0]=1 and shift_in[1]=0 constant.
   - Required: spi_clk high 4 and low 4 cycles.
   - Required: out_ready toggled every other cycle; all 16 words read 0x5555_5555, held stable while stalled.
3. **Input gaps.** in_valid deasserted for 5 cycles after word 7.
   - Required: in_ready stays high, no spi_clk activity until word 15 is accepted, and the shifted pattern is unchanged.
4. **Multi-frame write-only with flush.** frames=3, extra=2.
   - Required: 3×16 words consumed, 770 spi_clk pulses total, frame_cnt=3, zeros on shift_out during the last 2 pulses.
5. **Abort mid-shift.** abort asserted at bit 100 of frame 1.
   - Required: next cycle busy=0 and spi_clk=0, no done pulse; a new start then runs normally.
6. **No-op and start while busy.** frames=0 → done the cycle after start with no spi_clk. A start pulse while busy is ignored, with no change to frame_cnt or timing.
